bs_rnd_sat_2_2: RTL
===================

BS_RND_SAT_2_2 -- requirements
Module: bs_rnd_sat_2_2

Interface
REQ-001 SHALL have parameter T_0_DAT_WIDTH, default 20, packed input word width {neg_flag, pre_sat, round_flag, sign, data[15:0]}.
REQ-002 SHALL have parameter I_0_DAT_WIDTH, default 16, output sample width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, saturation event counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port t_0_dat  input  20  packed word: bit19 neg_flag, bit18 pre_sat, bit17 round_flag, bit16 sign, bits15:0 shifted data.
REQ-007 SHALL have port t_0_valid  input  1  upstream word valid.
REQ-008 SHALL have port t_0_ready  output  1  block accepts the word this cycle.
REQ-009 SHALL have port i_0_dat  output  16  final rounded/saturated two's-complement sample.
REQ-010 SHALL have port i_0_sat  output  1  sample on i_0_dat was clamped, qualified by i_0_valid.
REQ-011 SHALL have port i_0_valid  output  1  output sample valid.
REQ-012 SHALL have port i_0_ready  input  1  downstream accepts the sample.
REQ-013 SHALL have port cnt_clr  input  1  synchronous clear of sat_cnt.
REQ-014 SHALL have port sat_cnt  output  16  count of clamped samples delivered downstream.

Function
REQ-015 SHALL transfer a word on t_0 only when t_0_valid and t_0_ready are both 1, and on i_0 only when i_0_valid and i_0_ready are both 1.
REQ-016 SHALL use a two-stage pipeline, S1 (decode plus round add) and S2 (clamp plus output register), each with its own valid bit.
REQ-017 SHALL have a fixed latency of 2 cycles: a word accepted in cycle N appears on i_0 in cycle N+2 when there is no backpressure.
REQ-018 SHALL sustain a throughput of 1 word per cycle when i_0_ready is held at 1.
REQ-019 SHALL drive t_0_ready = ~S1_valid | ~S2_valid | i_0_ready, a combinational path from i_0_ready permitted.
REQ-020 SHALL advance S2 when ~S2_valid | i_0_ready, and S1 into S2 under the same condition.
REQ-021 SHALL hold i_0_dat, i_0_sat and i_0_valid stable while i_0_valid=1 and i_0_ready=0.
REQ-022 SHALL lose, duplicate or reorder no words under any valid/ready pattern.
REQ-023 SHALL compute the rounded value (S1) as data + round_flag in 17-bit signed arithmetic, with sign bit16 as the extension.
REQ-024 SHALL flag round overflow when sign=0, data=0x7FFF and round_flag=1.
REQ-025 SHALL treat negative wrap data=0xFFFF with round_flag=1 as a normal result of 0x0000, not a clamp.
REQ-026 SHALL select the S2 output by strict priority:
- neg_flag=1 → 0x0000, sat=1.
- else pre_sat=1 and sign=0 → 0x7FFF, sat=1.
- else pre_sat=1 and sign=1 → 0x8000, sat=1.
- else round overflow → 0x7FFF, sat=1.
- else the rounded value[15:0], sat=0.
REQ-027 SHALL increment sat_cnt by 1 on each i_0 handshake with i_0_sat=1.
REQ-028 SHALL hold sat_cnt at all-ones and never wrap.
REQ-029 SHALL make cnt_clr take priority over a simultaneous increment, so sat_cnt=0 the next cycle.
REQ-030 SHALL ignore t_0_dat contents when t_0_valid=0, and SHALL keep X on t_0_dat from propagating into the valid bits.

Reset
REQ-031 SHALL, when reset=1 at a clock edge, clear S1_valid, S2_valid and sat_cnt to 0, and drive i_0_valid=0, i_0_sat=0 and i_0_dat=0x0000 on the next cycle.
REQ-032 SHALL drive t_0_ready=1 in the first cycle after reset deasserts.
REQ-033 SHALL discard in-flight words on reset mid-stream and deliver no partial output afterwards.
REQ-034 SHALL let reset override cnt_clr and all handshakes.

Verification
REQ-035 SHALL cover passthrough: t_0_dat=0x01234, ready=1 → i_0_dat=0x1234, i_0_sat=0 at cycle N+2.
REQ-036 SHALL cover rounding: 0x21234 → 0x1235, sat=0; 0x27FFF → 0x7FFF, sat=1, sat_cnt 0→1; 0x3FFFF → 0x0000, sat=0.
REQ-037 SHALL cover clamp priority: 0x40000 → 0x7FFF; 0x50000 → 0x8000; 0x9FFFF → 0x0000; 0xDFFFF → 0x0000; all sat=1, sat_cnt=4.
REQ-038 SHALL cover backpressure: stream 0x00001..0x00005 back-to-back with i_0_ready=0 for cycles 2-5 → t_0_ready falls once 2 words are held, then outputs 0x0001..0x0005 in order with no gaps after release.
REQ-039 SHALL cover counter edges: preload to 0xFFFE, 3 clamped samples → 0xFFFF held; cnt_clr coincident with a clamped handshake → 0x0000.
REQ-040 SHALL cover reset mid-stream: reset=1 with both stages valid → i_0_valid=0 next cycle, sat_cnt=0, t_0_ready=1, and no stale sample after reset deasserts.

Source files
------------

// File: rtl/bs_rnd_sat_2_2.sv
// Round-and-saturate back end: S1 decodes the packed word and adds the round bit,
// S2 clamps by priority and registers the output sample; counts clamped deliveries.
module bs_rnd_sat_2_2 #(
  parameter int unsigned T_0_DAT_WIDTH = 20,
  parameter int unsigned I_0_DAT_WIDTH = 16,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [T_0_DAT_WIDTH-1:0] t_0_dat,
  input  logic                     t_0_valid,
  output logic                     t_0_ready,
  output logic [I_0_DAT_WIDTH-1:0] i_0_dat,
  output logic                     i_0_sat,
  output logic                     i_0_valid,
  input  logic                     i_0_ready,
  input  logic                     cnt_clr,
  output logic [CNT_WIDTH-1:0]     sat_cnt
);

  localparam int unsigned DW = I_0_DAT_WIDTH;
  localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

  // Field positions in the packed input word.
  localparam int unsigned NEG_BIT  = T_0_DAT_WIDTH - 1;
  localparam int unsigned PRE_BIT  = T_0_DAT_WIDTH - 2;
  localparam int unsigned RND_BIT  = T_0_DAT_WIDTH - 3;
  localparam int unsigned SIGN_BIT = T_0_DAT_WIDTH - 4;

  logic          s1_valid;
  logic          s1_neg;
  logic          s1_pre;
  logic          s1_sign;
  logic          s1_ovf;
  logic [DW-1:0] s1_val;

  logic          in_neg;
  logic          in_pre;
  logic          in_rnd;
  logic          in_sign;
  logic [DW-1:0] in_data;
  logic [DW-1:0] rnd_val;
  logic          rnd_ovf;

  logic          advance;
  logic [DW-1:0] sel_dat;
  logic          sel_sat;
  logic          sat_hs;

  // S2 moves whenever its slot is empty or being drained; S1 can fill if it empties too.
  assign advance   = ~i_0_valid | i_0_ready;
  assign t_0_ready = ~s1_valid | ~i_0_valid | i_0_ready;
  assign sat_hs    = i_0_valid & i_0_ready & i_0_sat;

  // Decode and round add. Only the low DW bits of the sign-extended sum are kept;
  // the -1 + 1 wrap naturally lands on zero and the +max + 1 case is flagged.
  always_comb begin
    in_neg  = t_0_dat[NEG_BIT];
    in_pre  = t_0_dat[PRE_BIT];
    in_rnd  = t_0_dat[RND_BIT];
    in_sign = t_0_dat[SIGN_BIT];
    in_data = t_0_dat[DW-1:0];
    rnd_val = in_data + DW'(in_rnd);
    rnd_ovf = ~in_sign & (in_data == POS_MAX) & in_rnd;
  end

  // Clamp selection by strict priority.
  always_comb begin
    sel_dat = s1_val;
    sel_sat = 1'b0;
    if (s1_neg) begin
      sel_dat = '0;
      sel_sat = 1'b1;
    end else if (s1_pre && !s1_sign) begin
      sel_dat = POS_MAX;
      sel_sat = 1'b1;
    end else if (s1_pre && s1_sign) begin
      sel_dat = NEG_MIN;
      sel_sat = 1'b1;
    end else if (s1_ovf) begin
      sel_dat = POS_MAX;
      sel_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      i_0_valid <= 1'b0;
      i_0_sat   <= 1'b0;
      i_0_dat   <= '0;
      sat_cnt   <= '0;
    end else begin
      if (t_0_ready) begin
        s1_valid <= t_0_valid;
        if (t_0_valid) begin
          s1_neg  <= in_neg;
          s1_pre  <= in_pre;
          s1_sign <= in_sign;
          s1_ovf  <= rnd_ovf;
          s1_val  <= rnd_val;
        end
      end
      if (advance) begin
        i_0_valid <= s1_valid;
        if (s1_valid) begin
          i_0_dat <= sel_dat;
          i_0_sat <= sel_sat;
        end
      end
      // Clear wins over a coincident increment; the count sticks at all-ones.
      if (cnt_clr) begin
        sat_cnt <= '0;
      end else if (sat_hs && (sat_cnt != '1)) begin
        sat_cnt <= sat_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
